mux_8x1_8bit_reg: RTL and testbench

- 8-input, 8-bit-wide selector used in the ALU result path. A 3-bit select S routes one of I0..I7 to the output.
- Combinational output Y follows inputs and select with zero cycle latency; the ALU result bus depends on this.
- Registered copy Y_Q, with enable, feeds downstream pipeline or stage logic on the single clock.

---
 rtl/mux_8x1_8bit_reg.sv | 37 +++
 tb/tb_mux_8x1_8bit_reg.sv | 111 +++++++++++
 2 files changed

// File: rtl/mux_8x1_8bit_reg.sv
// mux_8x1_8bit_reg: 8:1 data selector with combinational output and enabled registered copy
module mux_8x1_8bit_reg #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [WIDTH-1:0] I4,
    input  logic [WIDTH-1:0] I5,
    input  logic [WIDTH-1:0] I6,
    input  logic [WIDTH-1:0] I7,
    input  logic [2:0]       S,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_Q
);
    logic [WIDTH-1:0] in [8];

    assign in = '{I0, I1, I2, I3, I4, I5, I6, I7};

    // Unsigned index into the input table; an unknown select propagates X to Y
    always_comb begin
        Y = in[S];
    end

    // Registered copy of Y; asynchronous reset takes priority over capture
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            Y_Q <= RESET_VALUE;
        else if (EN)
            Y_Q <= Y;
    end
endmodule

// File: tb/tb_mux_8x1_8bit_reg.sv
// tb_mux_8x1_8bit_reg: directed scoreboard bench for the selector and its register
module tb_mux_8x1_8bit_reg;
    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       EN = 1'b0;
    logic [7:0] I0 = '0, I1 = '0, I2 = '0, I3 = '0;
    logic [7:0] I4 = '0, I5 = '0, I6 = '0, I7 = '0;
    logic [2:0] S = '0;
    logic [7:0] Y, Y_Q;

    logic [7:0] q [$];
    int checks = 0;
    int errors = 0;

    mux_8x1_8bit_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN),
        .I0(I0), .I1(I1), .I2(I2), .I3(I3),
        .I4(I4), .I5(I5), .I6(I6), .I7(I7),
        .S(S), .Y(Y), .Y_Q(Y_Q)
    );

    task automatic chk(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
        end else begin
            exp = q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic tick();
        #4 CLK = 1'b1;
        #1 CLK = 1'b0;
    endtask

    initial begin
        logic [7:0] lo_exp [4];
        logic [7:0] hi_exp [4];
        logic signed [2:0] ss;
        lo_exp = '{8'd12, 8'd2, 8'd5, 8'd1};
        hi_exp = '{8'h80, 8'hFF, 8'h55, 8'hAA};

        #2 RESET = 1'b1;
        q.push_back(8'h00); #1 chk("reset_state", Y_Q);
        RESET = 1'b0;

        I0 = 8'd12; I1 = 8'd2; I2 = 8'd5; I3 = 8'd1;
        for (int i = 0; i < 4; i++) begin
            S = 3'(i);
            q.push_back(lo_exp[i]); #1 chk("comb_lo", Y);
        end

        I3 = 8'd10;
        q.push_back(8'd10); #1 chk("input_change", Y);

        for (int i = 4; i < 8; i++) begin
            S = 3'(i);
            q.push_back(8'h00); #1 chk("tied_off", Y);
        end

        I4 = 8'h80; I5 = 8'hFF; I6 = 8'h55; I7 = 8'hAA;
        for (int i = 4; i < 8; i++) begin
            S = 3'(i);
            q.push_back(hi_exp[i-4]); #1 chk("comb_hi", Y);
        end

        ss = -3'sd1;
        S = ss;
        q.push_back(8'hAA); #1 chk("signed_sel", Y);

        #2 RESET = 1'b1;
        q.push_back(8'h00); #1 chk("async_reset", Y_Q);
        RESET = 1'b0; EN = 1'b1; S = 3'd2; I2 = 8'd5;
        q.push_back(8'h00); #1 chk("before_edge", Y_Q);
        tick();
        q.push_back(8'd5); chk("capture", Y_Q);

        EN = 1'b0; S = 3'd0;
        tick();
        q.push_back(8'd5); chk("hold1", Y_Q);
        tick();
        q.push_back(8'd5); chk("hold2", Y_Q);
        q.push_back(8'd12); chk("hold_y", Y);

        EN = 1'b1;
        tick();
        q.push_back(8'd12); chk("enable", Y_Q);

        #2 RESET = 1'b1;
        q.push_back(8'h00); #1 chk("midop_reset", Y_Q);
        q.push_back(8'd12); chk("y_in_reset", Y);
        I0 = 8'd33;
        q.push_back(8'd33); #1 chk("y_track_reset", Y);

        #4 CLK = 1'b1;
        RESET <= 1'b0;
        #1 CLK = 1'b0;
        q.push_back(8'h00); chk("release_edge", Y_Q);
        tick();
        q.push_back(8'd33); chk("resume", Y_Q);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
